// File: rtl/comparator_sweep_driver.sv
// ============================================================================
// Module   : comparator_sweep_driver
// Brief    : Exhaustive sweep driver/checker for an equality comparator.
//            Optional first-failure capture under CMP_DRV_FAIL_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_sweep_driver #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_out,
   output logic [WIDTH-1:0] first_word,
   output logic [WIDTH-1:0] second_word,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count
`ifdef CMP_DRV_FAIL_LOG_EN
   ,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_first,
   output logic [WIDTH-1:0] fail_second
`endif
);

   localparam int             c_IDX_W       = 2 * WIDTH;
   localparam logic [3:0]     c_SETTLE_LOAD = 4'(SETTLE - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = {c_IDX_W{1'b1}};

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_DRIVE  = 3'd1;
   localparam logic [2:0] c_WAIT   = 3'd2;
   localparam logic [2:0] c_SAMPLE = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd4;

   logic [2:0]         r_state;
   logic [c_IDX_W-1:0] r_idx;
   logic [3:0]         r_settle;

   logic               w_expected;
   logic               w_mismatch;
   logic [15:0]        w_err_next;

   // The words are already registered from r_idx, so the expectation comes from them.
   assign w_expected = (first_word == second_word);
   assign w_mismatch = (cmp_out != w_expected);
   assign w_err_next = (w_mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

   assign busy = (r_state != c_IDLE);
   assign done = (r_state == c_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_idx       <= '0;
         r_settle    <= '0;
         first_word  <= '0;
         second_word <= '0;
         pass        <= 1'b0;
         err_count   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_idx     <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  r_state   <= c_DRIVE;
               end
            end
            c_DRIVE: begin
               first_word  <= r_idx[c_IDX_W-1:WIDTH];
               second_word <= r_idx[WIDTH-1:0];
               r_settle    <= c_SETTLE_LOAD;
               r_state     <= c_WAIT;
            end
            c_WAIT: begin
               if (r_settle == 4'd0) begin
                  r_state <= c_SAMPLE;
               end else begin
                  r_settle <= r_settle - 4'd1;
               end
            end
            c_SAMPLE: begin
               err_count <= w_err_next;
               if (r_idx == c_IDX_LAST) begin
                  // Verdict includes the final sample so it is valid while done is high.
                  pass    <= (w_err_next == 16'd0);
                  r_state <= c_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= c_DRIVE;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

`ifdef CMP_DRV_FAIL_LOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_valid  <= 1'b0;
         fail_first  <= '0;
         fail_second <= '0;
      end else if ((r_state == c_IDLE) && start) begin
         fail_valid  <= 1'b0;
         fail_first  <= '0;
         fail_second <= '0;
      end else if ((r_state == c_SAMPLE) && w_mismatch && !fail_valid) begin
         fail_valid  <= 1'b1;
         fail_first  <= first_word;
         fail_second <= second_word;
      end
   end
`endif

endmodule

`default_nettype wire
